// File: rtl/msg_scroller.sv
// ============================================================================
// Module   : msg_scroller
// Purpose  : Message store with a scrolling four-character window for the
//            four-digit LED driver. MSG_SCROLLER_REVERSE_EN adds a dir input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module msg_scroller #(
  parameter int MSG_LEN       = 16,
  parameter int SCROLL_PERIOD = 25000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       step,
`ifdef MSG_SCROLLER_REVERSE_EN
  input  logic                       dir,
`endif
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  output logic [3:0]                 char3,
  output logic [3:0]                 char2,
  output logic [3:0]                 char1,
  output logic [3:0]                 char0,
  output logic                       advance
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int CW = $clog2(SCROLL_PERIOD);

  logic [3:0]    msg_q [MSG_LEN];
  logic [3:0]    msg_d [MSG_LEN];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    char3_q, char2_q, char1_q, char0_q;
  logic [3:0]    char3_d, char2_d, char1_d, char0_d;
  logic          advance_q, advance_d;
  logic          tick;
  logic          adv_req;

  always_comb begin
    tick      = run && (cnt_q == CW'(SCROLL_PERIOD - 1));
    // tick and step merge into a single request, so never a double advance
    adv_req   = tick || step;
    cnt_d     = '0;
    if (run && !tick) begin
      cnt_d = cnt_q + CW'(1);
    end
    ptr_d = ptr_q;
    if (adv_req) begin
`ifdef MSG_SCROLLER_REVERSE_EN
      ptr_d = dir ? (ptr_q - AW'(1)) : (ptr_q + AW'(1));
`else
      ptr_d = ptr_q + AW'(1);
`endif
    end
    msg_d = msg_q;
    if (wr_en) begin
      msg_d[wr_addr] = wr_data;
    end
    // window reads the pre-edge pointer/store, giving one cycle of lag
    char3_d   = msg_q[ptr_q];
    char2_d   = msg_q[ptr_q + AW'(1)];
    char1_d   = msg_q[ptr_q + AW'(2)];
    char0_d   = msg_q[ptr_q + AW'(3)];
    advance_d = adv_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= 4'(i);
      end
      ptr_q     <= '0;
      cnt_q     <= '0;
      char3_q   <= 4'd0;
      char2_q   <= 4'd1;
      char1_q   <= 4'd2;
      char0_q   <= 4'd3;
      advance_q <= 1'b0;
    end else begin
      msg_q     <= msg_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      char3_q   <= char3_d;
      char2_q   <= char2_d;
      char1_q   <= char1_d;
      char0_q   <= char0_d;
      advance_q <= advance_d;
    end
  end

  assign char3   = char3_q;
  assign char2   = char2_q;
  assign char1   = char1_q;
  assign char0   = char0_q;
  assign advance = advance_q;

endmodule

`default_nettype wire

// File: tb/tb_msg_scroller.sv
// ============================================================================
// Module   : tb_msg_scroller
// Purpose  : Scoreboard bench for msg_scroller (MSG_LEN=16, SCROLL_PERIOD=4);
//            honours MSG_SCROLLER_REVERSE_EN for the dir input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_msg_scroller;

  localparam int L = 16;
  localparam int P = 4;

  typedef struct packed {
    logic [15:0] chars;
    logic        adv;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       dir = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [3:0] wr_data = 4'd0;
  logic [3:0] char3, char2, char1, char0;
  logic       advance;

  int n_cmp = 0;
  int n_err = 0;
  bit done = 1'b0;
  exp_t sb[$];

  int m_msg[L];
  int m_ptr;
  int m_cnt;

  msg_scroller #(.MSG_LEN(L), .SCROLL_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
`ifdef MSG_SCROLLER_REVERSE_EN
    .dir(dir),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .char3(char3), .char2(char2), .char1(char1), .char0(char0),
    .advance(advance)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < L; i++) m_msg[i] = i % 16;
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  function automatic logic [15:0] window();
    return {4'(m_msg[m_ptr]), 4'(m_msg[(m_ptr + 1) % L]),
            4'(m_msg[(m_ptr + 2) % L]), 4'(m_msg[(m_ptr + 3) % L])};
  endfunction

  // Reference: what the outputs must show after the coming rising edge.
  function automatic exp_t model_edge(bit r, bit s, bit d, bit we, int wa, int wd);
    exp_t e;
    bit   tick;
    if (reset) begin
      model_reset();
      e.chars = 16'h0123;
      e.adv   = 1'b0;
      return e;
    end
    tick    = r && (m_cnt == P - 1);
    e.chars = window();
    e.adv   = tick || s;
    m_cnt   = r ? (m_cnt + 1) % P : 0;
    if (tick || s) m_ptr = d ? (m_ptr + L - 1) % L : (m_ptr + 1) % L;
    if (we) m_msg[wa] = wd;
    return e;
  endfunction

  task automatic drive(bit rs, bit r, bit s, bit d, bit we, int wa, int wd);
    @(negedge clk);
    reset   = rs;
    run     = r;
    step    = s;
`ifdef MSG_SCROLLER_REVERSE_EN
    dir     = d;
`else
    dir     = 1'b0;
`endif
    wr_en   = we;
    wr_addr = 4'(wa);
    wr_data = 4'(wd);
    sb.push_back(model_edge(r, s, dir, we, wa, wd));
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if ({char3, char2, char1, char0} !== e.chars) begin
        n_err++;
        $display("FAIL chars @%0t: got %h want %h", $time,
                 {char3, char2, char1, char0}, e.chars);
      end
      n_cmp++;
      if (advance !== e.adv) begin
        n_err++;
        $display("FAIL advance @%0t: got %b want %b", $time, advance, e.adv);
      end
    end
  end

  initial begin
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
    // step lands on the 4th run edge, which is the tick edge
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 10);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 5, 12);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({char3, char2, char1, char0} !== 16'h0123 || advance !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got %h/%b want 0123/0",
               {char3, char2, char1, char0}, advance);
    end
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0);
`ifdef MSG_SCROLLER_REVERSE_EN
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
`endif
    begin
      bit r;
      bit d;
      r = 1'b0;
      d = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) r = ~r;
        if ($urandom_range(0, 29) == 0) d = ~d;
        drive($urandom_range(0, 149) == 0, r, $urandom_range(0, 6) == 0, d,
              $urandom_range(0, 4) == 0, int'($urandom_range(0, L - 1)),
              int'($urandom_range(0, 15)));
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    done = 1'b1;
  end

  initial begin
    wait (done);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected responses left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
